// File: rtl/p16_pkg.sv
// Shared constants and meter state type for the 16-sample-per-clock datapath
// (generator, serializer and edge period meter).
package p16_pkg;

  localparam int SAMPLES_PER_WORD = 16;
  localparam int SUB_BITS         = 4;

  typedef enum logic [1:0] {
    HUNT,
    ARMED,
    TRACK
  } meter_state_t;

endpackage

// File: rtl/p16_first_rise_finder.sv
// Combinational search for the earliest 0->1 transition in a 16-sample word,
// using the last sample of the previous word as the sample before s[0].
module p16_first_rise_finder
  import p16_pkg::*;
(
  input  logic                        prev,
  input  logic [SAMPLES_PER_WORD-1:0] word,
  output logic                        found,
  output logic [SUB_BITS-1:0]         index
);

  // ext[SAMPLES_PER_WORD-i] is s[i-1] and ext[SAMPLES_PER_WORD-1-i] is s[i]
  logic [SAMPLES_PER_WORD:0] ext;

  assign ext = {prev, word};

  // Scan from the latest sample down so the earliest edge is the final write
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = SAMPLES_PER_WORD - 1; i >= 0; i--) begin
      if (!ext[SAMPLES_PER_WORD-i] && ext[SAMPLES_PER_WORD-1-i]) begin
        found = 1'b1;
        index = SUB_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/p16_edge_period_meter.sv
// Measures rising-edge to rising-edge period, in sample units, of a stream of
// 16-sample words and drives a period/strobe pair for the signal generator.
module p16_edge_period_meter
  import p16_pkg::*;
#(
  parameter int PERIOD_WIDTH  = 32,
  parameter int MIN_PERIOD    = 16,
  parameter int TIMEOUT_WORDS = 4096
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [SAMPLES_PER_WORD-1:0] p_in,
  input  logic                        p_in_valid,
  output logic [PERIOD_WIDTH-1:0]     period_out,
  output logic                        period_valid,
  output logic                        locked,
  output logic                        timeout
);

  localparam int WORD_BITS = PERIOD_WIDTH - SUB_BITS;
  localparam int TO_BITS   = $clog2(TIMEOUT_WORDS + 1);

  meter_state_t            state;
  logic [WORD_BITS-1:0]    word_count;
  logic                    prev_sample;
  logic [PERIOD_WIDTH-1:0] ts_last;
  logic [PERIOD_WIDTH-1:0] ts_edge;
  logic [PERIOD_WIDTH-1:0] candidate;
  logic [TO_BITS-1:0]      timeout_count;
  logic [TO_BITS-1:0]      timeout_next;
  logic                    edge_found;
  logic [SUB_BITS-1:0]     edge_index;
  logic                    accept;

  p16_first_rise_finder u_finder (
    .prev  (prev_sample),
    .word  (p_in),
    .found (edge_found),
    .index (edge_index)
  );

  // Timestamps are modular, so subtraction stays correct across word_count wrap
  assign ts_edge      = {word_count, edge_index};
  assign candidate    = ts_edge - ts_last;
  assign accept       = edge_found &&
                        ((state == HUNT) || (candidate >= PERIOD_WIDTH'(MIN_PERIOD)));
  assign timeout_next = timeout_count + TO_BITS'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= HUNT;
      word_count    <= '0;
      prev_sample   <= 1'b1;
      ts_last       <= '0;
      timeout_count <= '0;
      period_out    <= '0;
      period_valid  <= 1'b0;
      locked        <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      if (p_in_valid) begin
        word_count  <= word_count + WORD_BITS'(1);
        prev_sample <= p_in[0];
        if (accept) begin
          ts_last       <= ts_edge;
          timeout_count <= '0;
          if (state == HUNT) begin
            state  <= ARMED;
            locked <= 1'b0;
          end else begin
            period_out   <= candidate;
            period_valid <= 1'b1;
            state        <= TRACK;
            locked       <= 1'b1;
          end
        end else if (state != HUNT) begin
          // An accepted edge in the same word already took the branch above
          if (timeout_next == TO_BITS'(TIMEOUT_WORDS)) begin
            timeout       <= 1'b1;
            state         <= HUNT;
            locked        <= 1'b0;
            timeout_count <= '0;
          end else begin
            timeout_count <= timeout_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_p16_edge_period_meter.sv
// Directed bench for p16_edge_period_meter: a wide-timestamp instance plus a
// 12-bit instance whose timestamp wraps during the long square-wave run.
module tb_p16_edge_period_meter;

  logic        clock;
  logic        reset;
  logic [15:0] p_in;
  logic        p_in_valid;

  logic [31:0] period_out;
  logic        period_valid;
  logic        locked;
  logic        timeout;

  logic [11:0] period_out2;
  logic        period_valid2;
  logic        locked2;
  logic        timeout2;

  int errors = 0;
  int checks = 0;
  int glitchAt = -1;

  p16_edge_period_meter #(
    .PERIOD_WIDTH  (32),
    .MIN_PERIOD    (16),
    .TIMEOUT_WORDS (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .p_in         (p_in),
    .p_in_valid   (p_in_valid),
    .period_out   (period_out),
    .period_valid (period_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  p16_edge_period_meter #(
    .PERIOD_WIDTH  (12),
    .MIN_PERIOD    (16),
    .TIMEOUT_WORDS (8)
  ) dutWrap (
    .clock        (clock),
    .reset        (reset),
    .p_in         (p_in),
    .p_in_valid   (p_in_valid),
    .period_out   (period_out2),
    .period_valid (period_valid2),
    .locked       (locked2),
    .timeout      (timeout2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge
  task automatic applyStimulus(input logic [15:0] word, input logic valid,
                               input logic rst);
    @(negedge clock);
    p_in       = word;
    p_in_valid = valid;
    reset      = rst;
    @(posedge clock);
    #1;
  endtask

  // Square wave of period 70 samples: 35 low then 35 high, starting low
  function automatic logic sampleAt(int t);
    return ((t % 70) >= 35) && (t != glitchAt);
  endfunction

  function automatic logic [15:0] waveWord(int w);
    logic [15:0] wd;
    for (int i = 0; i < 16; i++) wd[15-i] = sampleAt(16 * w + i);
    return wd;
  endfunction

  // Edges sit at 35 + 70k; every edge after the first produces a report
  function automatic logic strobeExpected(int w);
    for (int i = 0; i < 16; i++) begin
      if ((16 * w + i) > 35 && ((16 * w + i) % 70) == 35) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic runWave(input int firstW, input int lastW, input bit checkWrap);
    logic e;
    for (int w = firstW; w <= lastW; w++) begin
      applyStimulus(waveWord(w), 1'b1, 1'b0);
      e = strobeExpected(w);
      checkOutput("wave_valid", period_valid, e);
      checkOutput("wave_locked", locked, (w >= 6));
      if (e) checkOutput("wave_period", period_out, 70);
      if (checkWrap) begin
        checkOutput("wrap_valid", period_valid2, e);
        if (e) checkOutput("wrap_period", period_out2, 70);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    p_in       = '0;
    p_in_valid = 1'b0;

    applyStimulus(16'h0000, 1'b0, 1'b1);
    applyStimulus(16'h0000, 1'b0, 1'b1);
    checkOutput("reset_period", period_out, 0);
    checkOutput("reset_valid", period_valid, 0);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_timeout", timeout, 0);

    // Wave with a low dip at 179 making a rejected edge at 180, 5 after 175
    glitchAt = 179;
    runWave(0, 20, 1'b1);

    for (int k = 0; k < 5; k++) begin
      applyStimulus(16'h5555, 1'b0, 1'b0);
      checkOutput("stall_valid", period_valid, 0);
      checkOutput("stall_timeout", timeout, 0);
    end
    checkOutput("stall_period", period_out, 70);
    checkOutput("stall_locked", locked, 1);
    runWave(21, 28, 1'b0);

    // Last edge at sample 455 in word 28; eight quiet words abandon tracking
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(16'h0000, 1'b1, 1'b0);
      checkOutput("to_strobe", timeout, (k == 8));
      checkOutput("to_locked", locked, (k < 8));
    end
    checkOutput("to_period_hold", period_out, 70);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("to_strobe_once", timeout, 0);
    applyStimulus(16'h00FF, 1'b1, 1'b0);
    checkOutput("rearm_valid", period_valid, 0);
    checkOutput("rearm_locked", locked, 0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h00FF, 1'b1, 1'b0);
    checkOutput("relock_valid", period_valid, 1);
    checkOutput("relock_period", period_out, 32);
    checkOutput("relock_locked", locked, 1);

    // Multi-edge word: only index 1 counts -> 2*16 + 1 - 8
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h5555, 1'b1, 1'b0);
    checkOutput("multi_valid", period_valid, 1);
    checkOutput("multi_period", period_out, 25);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    checkOutput("multi_once", period_valid, 0);
    // Word-boundary edge at index 0 -> 2*16 + 0 - 1
    applyStimulus(16'h8000, 1'b1, 1'b0);
    checkOutput("bound_valid", period_valid, 1);
    checkOutput("bound_period", period_out, 31);
    applyStimulus(16'h8000, 1'b1, 1'b0);
    checkOutput("min_eq_valid", period_valid, 1);
    checkOutput("min_eq_period", period_out, 16);
    applyStimulus(16'h4000, 1'b1, 1'b0);
    checkOutput("p17_period", period_out, 17);
    applyStimulus(16'h8000, 1'b1, 1'b0);
    checkOutput("min_below_valid", period_valid, 0);
    checkOutput("min_below_period", period_out, 17);
    applyStimulus(16'h8000, 1'b1, 1'b0);
    checkOutput("after_reject_valid", period_valid, 1);
    checkOutput("after_reject_period", period_out, 31);

    // Reset while tracking, with an edge word presented during reset
    applyStimulus(16'h8000, 1'b1, 1'b1);
    checkOutput("mid_reset_period", period_out, 0);
    checkOutput("mid_reset_valid", period_valid, 0);
    checkOutput("mid_reset_locked", locked, 0);
    checkOutput("mid_reset_timeout", timeout, 0);
    applyStimulus(16'h00FF, 1'b1, 1'b0);
    checkOutput("post_reset_valid", period_valid, 0);
    checkOutput("post_reset_locked", locked, 0);
    applyStimulus(16'h0000, 1'b1, 1'b0);
    applyStimulus(16'h00FF, 1'b1, 1'b0);
    checkOutput("post_reset_period", period_out, 32);
    checkOutput("post_reset_strobe", period_valid, 1);

    // Long run: the 12-bit instance wraps at sample 4096 (edge at 4095 then 4165)
    glitchAt = -1;
    applyStimulus(16'h0000, 1'b0, 1'b1);
    runWave(0, 299, 1'b1);
    checkOutput("wrap_locked", locked2, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500000 ns");
    $fatal(1);
  end

endmodule
